// File: rtl/init_sequencer.sv
// Staged power-up sequencer: each stage waits a delay, emits a one-cycle start pulse, then waits for its ack.
// Optional ack timeout with FAULT state: define INIT_SEQ_TIMEOUT_EN.
module init_sequencer #(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 20'hFFFFE,
  parameter int unsigned ACK_TIMEOUT = 20'hFFFFF
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iINITIAL_ENABLE,
  input  logic                  iRESTART,
  input  logic [NUM_STAGES-1:0] iSTAGE_ACK,
  output logic [NUM_STAGES-1:0] oSTAGE_START,
  output logic [3:0]            oSTAGE_IDX,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oFAULT
);

  if (NUM_STAGES < 1 || NUM_STAGES > 16 ||
      64'(STAGE_DELAY) > (64'd1 << CNT_W) - 64'd2 ||
      64'(ACK_TIMEOUT) > (64'd1 << CNT_W) - 64'd1 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("init_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_DELAY,
    S_PULSE,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DLY  = CNT_W'(STAGE_DELAY);
  localparam logic [3:0]       LAST = 4'(NUM_STAGES - 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [3:0]              idx, idx_nx;
  logic [15:0]             ack_ext;
  logic                    ack_hit;
  logic [NUM_STAGES-1:0]   start_nx;
  logic                    busy_nx, done_nx, fault_nx;

  assign ack_ext    = 16'(iSTAGE_ACK);
  assign ack_hit    = ack_ext[idx];
  assign oSTAGE_IDX = idx;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= S_DELAY;
      cnt          <= '0;
      idx          <= '0;
      oSTAGE_START <= '0;
      oBUSY        <= 1'b1;
      oDONE        <= 1'b0;
      oFAULT       <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      oSTAGE_START <= start_nx;
      oBUSY        <= busy_nx;
      oDONE        <= done_nx;
      oFAULT       <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (iRESTART) begin
      state_nx = S_DELAY;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      unique case (state)
        S_DELAY: begin
          // Counter parks at the delay value so a late enable still gets its pulse.
          if (cnt == DLY) begin
            if (iINITIAL_ENABLE) begin
              cnt_nx   = '0;
              state_nx = S_PULSE;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_PULSE: begin
          cnt_nx   = '0;
          state_nx = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ack_hit) begin
            cnt_nx = '0;
            if (idx == LAST) begin
              state_nx = S_DONE;
            end else begin
              idx_nx   = idx + 4'd1;
              state_nx = S_DELAY;
            end
          end
`ifdef INIT_SEQ_TIMEOUT_EN
          // Fault is entered on the edge where cnt would reach ACK_TIMEOUT.
          else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_nx = S_FAULT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
`else
          else if (cnt != '1) begin
            cnt_nx = cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE:  ;
        S_FAULT: ;
        default: state_nx = S_DELAY;
      endcase
    end
  end

  // Outputs are decoded from next state so they arrive registered with the state.
  always_comb begin
    start_nx = '0;
    if (state_nx == S_PULSE) begin
      start_nx = NUM_STAGES'(16'd1 << idx_nx);
    end
    busy_nx = (state_nx == S_DELAY) || (state_nx == S_PULSE) || (state_nx == S_WAIT_ACK);
    done_nx = (state_nx == S_DONE);
`ifdef INIT_SEQ_TIMEOUT_EN
    fault_nx = (state_nx == S_FAULT);
`else
    fault_nx = 1'b0;
`endif
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: CNT_W=8, STAGE_DELAY=10, NUM_STAGES=3, ACK_TIMEOUT=20.
module tb_init_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] ack = '0;
  logic [2:0] start;
  logic [3:0] idx;
  logic       busy, done, fault;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  init_sequencer #(
    .CNT_W       (8),
    .NUM_STAGES  (3),
    .STAGE_DELAY (10),
    .ACK_TIMEOUT (20)
  ) dut (
    .iCLK            (clk),
    .iRST_n          (rst_n),
    .iINITIAL_ENABLE (en),
    .iRESTART        (restart),
    .iSTAGE_ACK      (ack),
    .oSTAGE_START    (start),
    .oSTAGE_IDX      (idx),
    .oBUSY           (busy),
    .oDONE           (done),
    .oFAULT          (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_idx"},   32'(idx),   32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd1);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  // Release reset on a falling edge; that instant is cycle 0.
  task automatic do_reset(input logic enable);
    rst_n   = 1'b0;
    restart = 1'b0;
    ack     = '0;
    en      = enable;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Nominal three-stage run, acks 2 cycles after each pulse
    do_reset(1'b1);
    chk_reset_vals("reset");
    for (int c = 1; c <= 45; c++) begin
      adv();
      chk("t1_start", 32'(start), (c == 11) ? 32'd1 : (c == 25) ? 32'd2 : (c == 39) ? 32'd4 : 32'd0);
      chk("t1_idx",   32'(idx),   (c < 14) ? 32'd0 : (c < 28) ? 32'd1 : 32'd2);
      chk("t1_done",  32'(done),  (c >= 42) ? 32'd1 : 32'd0);
      chk("t1_busy",  32'(busy),  (c >= 42) ? 32'd0 : 32'd1);
      chk("t1_fault", 32'(fault), 32'd0);
      ack = (c == 13) ? 3'b001 : (c == 27) ? 3'b010 : (c == 41) ? 3'b100 : 3'b000;
    end
    restart = 1'b1;
    adv();
    restart = 1'b0;
    chk("rst_from_done_done",  32'(done),  32'd0);
    chk("rst_from_done_busy",  32'(busy),  32'd1);
    chk("rst_from_done_idx",   32'(idx),   32'd0);
    chk("rst_from_done_start", 32'(start), 32'd0);

    // Enable low until cycle 50
    do_reset(1'b0);
    for (int c = 1; c <= 50; c++) begin
      adv();
      chk("t2_nopulse", 32'(start), 32'd0);
    end
    en = 1'b1;
    adv();
    chk("t2_pulse", 32'(start), 32'd1);
    adv();
    chk("t2_single", 32'(start), 32'd0);
    chk("t2_busy",   32'(busy),  32'd1);

    // Wrong-stage ack in stage 0 WAIT_ACK (cycle 52)
    ack = 3'b100;
    for (int c = 53; c <= 60; c++) begin
      adv();
      chk("t3_idx",   32'(idx),   32'd0);
      chk("t3_start", 32'(start), 32'd0);
    end
    ack = 3'b001;
    adv();
    ack = 3'b000;
    chk("t3_adv_idx", 32'(idx), 32'd1);
    adv();
    chk("t3_adv_start", 32'(start), 32'd0);

    // Restart coinciding with stage-2 delay expiry (cycle 38)
    do_reset(1'b1);
    for (int c = 1; c <= 38; c++) begin
      adv();
      ack = (c == 13) ? 3'b001 : (c == 27) ? 3'b010 : 3'b000;
    end
    chk("t5_idx_before", 32'(idx), 32'd2);
    restart = 1'b1;
    adv();
    restart = 1'b0;
    chk("t5_nopulse", 32'(start), 32'd0);
    chk("t5_idx",     32'(idx),   32'd0);
    chk("t5_busy",    32'(busy),  32'd1);
    for (int c = 40; c <= 51; c++) begin
      adv();
      chk("t5_repulse", 32'(start), (c == 50) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset during stage-1 WAIT_ACK (cycle 26)
    do_reset(1'b1);
    for (int c = 1; c <= 26; c++) begin
      adv();
      ack = (c == 13) ? 3'b001 : 3'b000;
    end
    chk("t6_idx_before", 32'(idx), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 12; c++) begin
      adv();
      chk("t6_repulse", 32'(start), (c == 11) ? 32'd1 : 32'd0);
    end

`ifdef INIT_SEQ_TIMEOUT_EN
    // Stage-1 ack withheld: fault after 20 WAIT_ACK cycles (26..45)
    do_reset(1'b1);
    for (int c = 1; c <= 45; c++) begin
      adv();
      ack = (c == 13) ? 3'b001 : 3'b000;
    end
    chk("t4_fault_pre", 32'(fault), 32'd0);
    adv();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_busy",  32'(busy),  32'd0);
    chk("t4_idx",   32'(idx),   32'd1);
    restart = 1'b1;
    adv();
    restart = 1'b0;
    chk("t4_clear", 32'(fault), 32'd0);
    chk("t4_busy2", 32'(busy),  32'd1);
    chk("t4_idx2",  32'(idx),   32'd0);
    for (int c = 48; c <= 59; c++) begin
      adv();
      chk("t4_repulse", 32'(start), (c == 58) ? 32'd1 : 32'd0);
    end
`else
    // Stage-1 ack withheld: waits indefinitely, no fault, then a late ack still advances
    do_reset(1'b1);
    for (int c = 1; c <= 300; c++) begin
      adv();
      ack = (c == 13) ? 3'b001 : 3'b000;
    end
    chk("t4_nofault", 32'(fault), 32'd0);
    chk("t4_busy",    32'(busy),  32'd1);
    chk("t4_idx",     32'(idx),   32'd1);
    chk("t4_start",   32'(start), 32'd0);
    ack = 3'b010;
    adv();
    ack = 3'b000;
    chk("t4_late_ack_idx", 32'(idx), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Parametrised power-up sequencer. Generalises the single delayed start pulse into NUM_STAGES ordered start pulses.
- Each stage waits a programmable delay, then issues a one-cycle start pulse, then waits for the downstream block's acknowledge before moving to the next stage.
- Sits between the system reset/clock domain and peripheral configurators (codec, video decoder, I2C config blocks).
- Reports busy, done and fault status.

Parameters:
- CNT_W, 20, width of the delay/timeout counter.
- NUM_STAGES, 4, number of sequenced stages (1..16).
- STAGE_DELAY, 20'hFFFFE, cycles from stage entry to start pulse. Must be ≤ 2^CNT_W-2.
- ACK_TIMEOUT, 20'hFFFFF, maximum cycles to wait for an acknowledge. Only used with INIT_SEQ_TIMEOUT_EN.

Ports:
- iCLK, in, 1, system clock (50 MHz).
- iRST_n, in, 1, asynchronous active-low reset.
- iINITIAL_ENABLE, in, 1, level gate; start pulses are issued only while high.
- iRESTART, in, 1, synchronous one-cycle request to rerun the sequence from stage 0.
- iSTAGE_ACK, in, NUM_STAGES, per-stage completion acknowledge (level or pulse).
- oSTAGE_START, out, NUM_STAGES, one-hot, one-cycle start pulse for the current stage.
- oSTAGE_IDX, out, 4, index of the current stage.
- oBUSY, out, 1, high while the sequence is in progress.
- oDONE, out, 1, high once all stages are acknowledged; sticky until restart or reset.
- oFAULT, out, 1, high on acknowledge timeout; sticky until restart or reset.

Behaviour:
- Reset is iRST_n, asynchronous, active-low; clock is iCLK.
- Reset values: oSTAGE_START=0, oSTAGE_IDX=0, oBUSY=1, oDONE=0, oFAULT=0, cnt=0, state=DELAY.
- All state is registered; outputs are driven from registers, with no combinational path from inputs to outputs.
- DELAY state:
  - cnt increments by 1 each cycle.
  - When cnt==STAGE_DELAY and iINITIAL_ENABLE=1: load cnt=0, assert the pulse on the next clock edge, go to PULSE.
  - When cnt==STAGE_DELAY and iINITIAL_ENABLE=0: cnt saturates at STAGE_DELAY and the block waits. The pulse is never lost; it is issued on the first cycle enable is high.
- PULSE state:
  - oSTAGE_START[idx]=1 for exactly one cycle.
  - Next state is WAIT_ACK.
- WAIT_ACK state:
  - cnt counts from 0.
  - On iSTAGE_ACK[idx]=1: if idx==NUM_STAGES-1, go to DONE; otherwise idx+1, cnt=0, go to DELAY.
  - Acks from other stage indices are ignored.
  - An ack arriving in the same cycle as the pulse is not seen. Acks are sampled from the first WAIT_ACK cycle onward.
- DONE state: oDONE=1, oBUSY=0. Holds until iRESTART.
- FAULT state: oFAULT=1, oBUSY=0, oSTAGE_IDX frozen at the failing stage. Holds until iRESTART.
- iRESTART=1 in any state:
  - Next cycle: idx=0, cnt=0, state=DELAY, oDONE=0, oFAULT=0, oBUSY=1, and any pending pulse is cancelled.
  - Restart takes priority over ack and over delay expiry in the same cycle.
- iINITIAL_ENABLE deasserted mid-sequence:
  - Only blocks pulse issue in DELAY.
  - WAIT_ACK progress continues.
- Latency from stage entry to pulse: STAGE_DELAY+1 cycles when enable is high throughout.
- Asynchronous reset mid-operation: immediate return to the reset values.
- NUM_STAGES=1: behaviour degenerates to one delayed pulse, then DONE on ack.

Optional Feature:
- Macro: INIT_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_ACK, when cnt reaches ACK_TIMEOUT without an ack, go to FAULT and set oFAULT=1.
  - A timeout and an ack in the same cycle resolve as ack (ack wins).
- Undefined:
  - WAIT_ACK waits indefinitely, with cnt saturating at 2^CNT_W-1.
  - oFAULT is tied to 0.
  - The ACK_TIMEOUT parameter is unused.

Test Plan:
- CNT_W=8, STAGE_DELAY=10, NUM_STAGES=3, enable=1, each ack returned 2 cycles after its pulse:
  - Pulses at cycles 11, 25, 39 on bits 0, 1, 2.
  - oDONE rises 3 cycles after the last pulse; oBUSY falls in the same cycle.
- Enable held low until cycle 50, then raised:
  - No pulse before cycle 50.
  - oSTAGE_START[0] pulses exactly once, in the cycle after enable is sampled high.
- Wrong-stage ack: drive iSTAGE_ACK=3'b100 while in stage 0 WAIT_ACK:
  - Index stays 0 and no further pulse occurs.
  - A later ack on 3'b001 advances the index to 1.
- With INIT_SEQ_TIMEOUT_EN and ACK_TIMEOUT=20, withhold the stage-1 ack:
  - oFAULT=1, oBUSY=0 and oSTAGE_IDX=1 after 20 WAIT_ACK cycles.
  - iRESTART then clears oFAULT and re-pulses stage 0 after 11 cycles.
- iRESTART asserted in the same cycle as the stage-2 delay expiry:
  - No stage-2 pulse is issued.
  - The sequence restarts at stage 0.
- Assert iRST_n low for 1 cycle during WAIT_ACK of stage 1:
  - All outputs return to their reset values asynchronously.
  - Stage 0 re-pulses STAGE_DELAY+1 cycles after release.
